// File: rtl/mem_access_master.sv
// Memory-stage requester for the Y86 data path: moves one quadword per transaction
// as eight little-endian byte beats over a byte-wide synchronous memory port.
module mem_access_master #(
    parameter int unsigned MEM_SIZE = 1024,
    parameter int          ADDR_W   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    // Handshake rule for both req and resp: a transfer happens on a posedge where
    // valid and ready are both 1; the payload is held stable while valid waits.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    // Highest legal quadword base; the full-width compare also rejects bases near 2^64.
    localparam logic [ADDR_W-1:0] MAX_BASE = ADDR_W'(MEM_SIZE - 8);

    state_e            state_q, state_d;
    logic [2:0]        beat_q, beat_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              error_q, error_d;
    logic [2:0]        prev_beat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        base_d    = base_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        prev_beat = beat_q - 3'd1;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    base_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    beat_d  = '0;
                    if (req_addr > MAX_BASE) begin
                        error_d = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        error_d = 1'b0;
                        state_d = req_write ? S_WRITE : S_READ;
                    end
                end
            end
            S_WRITE: begin
                beat_d = beat_q + 3'd1;
                if (beat_q == 3'd7) begin
                    state_d = S_RESP;
                end
            end
            S_READ: begin
                // Read data trails the strobe by one cycle, so this beat lands the previous byte.
                if (beat_q != 3'd0) begin
                    rdata_d[{prev_beat, 3'b000} +: 8] = mem_rdata;
                end
                beat_d = beat_q + 3'd1;
                if (beat_q == 3'd7) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                rdata_d[63:56] = mem_rdata;
                beat_d         = '0;
                state_d        = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    error_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        resp_rdata = rdata_q;
        resp_error = error_q;
        case (state_q)
            S_IDLE: begin
                req_ready = rst_n;
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = base_q + ADDR_W'(beat_q);
                mem_wdata = wdata_q[{beat_q, 3'b000} +: 8];
            end
            S_READ: begin
                mem_re   = 1'b1;
                mem_addr = base_q + ADDR_W'(beat_q);
            end
            S_RESP: begin
                resp_valid = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_master.sv
// Directed bench for mem_access_master: byte memory model, strobe monitor,
// expected-beat queue and hand-computed responses.
module tb_mem_access_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_error;
    logic [63:0] mem_addr;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [0:1023];
    logic [23:0] wr_q [$];
    logic [15:0] rd_q [$];
    logic [23:0] exp_q [$];
    logic        both_seen = 1'b0;

    mem_access_master #(.MEM_SIZE(1024), .ADDR_W(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Clock and synchronous byte memory with one-cycle read latency
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem_rdata = 8'h00;
    end

    always @(posedge clk) begin
        if (mem_we && mem_addr < 64'd1024) mem[mem_addr[9:0]] <= mem_wdata;
        if (mem_re && mem_addr < 64'd1024) mem_rdata <= mem[mem_addr[9:0]];
    end

    // Strobe monitor
    always @(negedge clk) begin
        if (mem_we) wr_q.push_back({mem_addr[15:0], mem_wdata});
        if (mem_re) rd_q.push_back(mem_addr[15:0]);
        if (mem_we && mem_re) both_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            req_valid = 1'b0;
        end while (!resp_valid && lat < 40);
        check("resp_seen", 64'(resp_valid), 64'd1);
    endtask

    task automatic do_req(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                          input logic rr, output int lat);
        @(negedge clk);
        check("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wd;
        resp_ready = rr;
        @(posedge clk);
        wait_resp(lat);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, 64'(wr_q.size()), 64'(exp_q.size()));
        while (exp_q.size() != 0 && wr_q.size() != 0) begin
            check(tag, 64'(wr_q.pop_front()), 64'(exp_q.pop_front()));
        end
        exp_q.delete();
        wr_q.delete();
    endtask

    initial begin
        int lat;
        logic [63:0] held;

        // Reset with a request pending
        rst_n      = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 64'h10;
        req_wdata  = 64'hDEADBEEFCAFEF00D;
        resp_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_error", 64'(resp_error), 64'd0);
        check("rst_strobes", 64'({mem_we, mem_re}), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        rst_n     = 1'b1;
        req_valid = 1'b0;
        #1;
        check("rel_req_ready", 64'(req_ready), 64'd1);
        check("rst_no_writes", 64'(wr_q.size()), 64'd0);

        // Write 0x10
        wr_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({16'(16'h10 + i), 8'(8'h11 * (i + 1))});
        do_req(1'b1, 64'h10, 64'h8877665544332211, 1'b1, lat);
        check("wr_latency", 64'(lat), 64'd9);
        check("wr_error", 64'(resp_error), 64'd0);
        check("wr_rdata", resp_rdata, 64'd0);
        check_writes("wr_beat");

        // Read 0x10 back
        rd_q.delete();
        do_req(1'b0, 64'h10, 64'd0, 1'b1, lat);
        check("rd_latency", 64'(lat), 64'd10);
        check("rd_rdata", resp_rdata, 64'h8877665544332211);
        check("rd_error", 64'(resp_error), 64'd0);
        check("rd_beats", 64'(rd_q.size()), 64'd8);
        for (int i = 0; i < 8 && rd_q.size() != 0; i++) begin
            check("rd_addr", 64'(rd_q.pop_front()), 64'(16'h10 + i));
        end

        // Highest legal base
        for (int i = 0; i < 8; i++) exp_q.push_back({16'(16'd1016 + i), 8'(8'hA8 - i)});
        do_req(1'b1, 64'd1016, 64'hA1A2A3A4A5A6A7A8, 1'b1, lat);
        check("top_wr_latency", 64'(lat), 64'd9);
        check("top_wr_error", 64'(resp_error), 64'd0);
        check_writes("top_wr_beat");
        do_req(1'b0, 64'd1016, 64'd0, 1'b1, lat);
        check("top_rd_latency", 64'(lat), 64'd10);
        check("top_rd_rdata", resp_rdata, 64'hA1A2A3A4A5A6A7A8);

        // Out-of-range bases
        rd_q.delete();
        wr_q.delete();
        do_req(1'b1, 64'd1017, 64'h1111111111111111, 1'b1, lat);
        check("oob_wr_latency", 64'(lat), 64'd1);
        check("oob_wr_error", 64'(resp_error), 64'd1);
        check("oob_wr_rdata", resp_rdata, 64'd0);
        do_req(1'b0, 64'd1017, 64'd0, 1'b1, lat);
        check("oob_rd_latency", 64'(lat), 64'd1);
        check("oob_rd_error", 64'(resp_error), 64'd1);
        check("oob_rd_rdata", resp_rdata, 64'd0);
        do_req(1'b0, 64'hFFFFFFFFFFFFFFFC, 64'd0, 1'b1, lat);
        check("wrap_latency", 64'(lat), 64'd1);
        check("wrap_error", 64'(resp_error), 64'd1);
        check("oob_no_writes", 64'(wr_q.size()), 64'd0);
        check("oob_no_reads", 64'(rd_q.size()), 64'd0);

        // Response backpressure with a request waiting
        do_req(1'b0, 64'h10, 64'd0, 1'b0, lat);
        check("bp_latency", 64'(lat), 64'd10);
        held = resp_rdata;
        check("bp_rdata", held, 64'h8877665544332211);
        wr_q.delete();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h40;
        req_wdata = 64'h0102030405060708;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_hold", resp_rdata, 64'h8877665544332211);
            check("bp_req_ready", 64'(req_ready), 64'd0);
        end
        check("bp_ignored", 64'(wr_q.size()), 64'd0);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_taken", 64'(resp_valid), 64'd0);
        check("bp_ready_again", 64'(req_ready), 64'd1);
        @(posedge clk);
        wait_resp(lat);
        check("bp_next_latency", 64'(lat), 64'd9);
        do_req(1'b0, 64'h40, 64'd0, 1'b1, lat);
        check("bp_next_rdata", resp_rdata, 64'h0102030405060708);

        // Reset during write beat 3
        @(negedge clk);
        wr_q.delete();
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 64'h10;
        req_wdata  = 64'hF0E0D0C0B0A09080;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("abort_beat3_addr", mem_addr, 64'h13);
        check("abort_beat3_data", 64'(mem_wdata), 64'hB0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_no_resp", 64'(resp_valid), 64'd0);
        check("abort_no_we", 64'(mem_we), 64'd0);
        rst_n = 1'b1;
        #1;
        check("abort_idle", 64'(req_ready), 64'd1);
        check("abort_bytes", 64'(wr_q.size()), 64'd4);
        do_req(1'b0, 64'h10, 64'd0, 1'b1, lat);
        check("abort_rd_rdata", resp_rdata, 64'h88776655B0A09080);

        @(negedge clk);
        check("we_re_exclusive", 64'(both_seen), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_master.md
Name: mem_access_master

Overview:
- Requester-side controller for the Y86 data memory path: accepts one quadword read or write per transaction from the pipeline memory stage.
- Serialises each quadword into eight little-endian byte beats on a byte-wide synchronous memory port, and reassembles read bytes into a quadword.
- Bounds-checks every request against the memory size and returns an address-error status instead of touching memory.
- Sits between the memory stage and the byte-wide data memory.

Parameters:
- MEM_SIZE, 1024: bytes of data memory; a legal quadword base satisfies addr <= MEM_SIZE-8.
- ADDR_W, 64: address width (`QWORD).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  master can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  64  quadword base byte address.
- req_wdata  in  64  write data; byte i = bits [8i+7:8i].
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  64  assembled read data; 0 for writes and errors.
- resp_error  out  1  address out of range; no memory access occurred.
- mem_addr  out  64  byte address for the current beat.
- mem_we  out  1  byte write strobe.
- mem_re  out  1  byte read strobe.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte, valid exactly 1 cycle after mem_re.

Behaviour:
- Reset (rst_n=0 at posedge) forces the following, regardless of state:
  - state=IDLE.
  - Outputs: req_ready=1 on the cycle after reset releases; resp_valid=0, resp_rdata=0, resp_error=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
  - Beat counter = 0.
- Reset mid-transaction aborts the transaction. Bytes already written stay in memory; no response is produced.
- States: IDLE, WRITE, READ, DRAIN, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1, latch addr, wdata and write, and clear resp_rdata.
  - If addr > MEM_SIZE-8, go to RESP with resp_error=1.
  - Otherwise go to WRITE or READ with beat=0.
- WRITE:
  - mem_we=1, mem_addr=base+beat, mem_wdata=wdata byte[beat].
  - beat increments each cycle; after beat 7, go to RESP.
- READ:
  - mem_re=1, mem_addr=base+beat.
  - Each cycle with beat>=1, capture mem_rdata into resp_rdata byte[beat-1].
  - After beat 7, go to DRAIN.
- DRAIN:
  - No strobes.
  - Capture mem_rdata into byte[7], then go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_error are held stable.
  - req_ready=0.
  - On resp_ready=1, go to IDLE and clear resp_valid and resp_error.
  - Back-to-back transactions are allowed: the next request can be accepted on the cycle after the response is taken.
- Outside the beat states, mem_we, mem_re and mem_wdata are 0. mem_we and mem_re are never both 1.
- Requests are ignored whenever req_ready=0. No queueing.
- Latency, with the accept edge = cycle 0 and resp_ready held high:
  - write: resp_valid first high in cycle 9;
  - read: resp_valid first high in cycle 10;
  - error: resp_valid first high in cycle 1.
- Bounds-check boundaries:
  - addr=MEM_SIZE-8 is legal.
  - addr=MEM_SIZE-7 is an error.
  - Any addr whose addr+7 would wrap past 2^64-1 is an error; the compare is done on the full 64-bit address.
- Beat address arithmetic is 64-bit; it never wraps for legal bases.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req_valid=1 -> all outputs 0, no strobes. req_ready=1 on the first cycle after release.
- Write: addr=0x10, wdata=0x8877665544332211 -> mem_we on 8 consecutive cycles with addr 0x10..0x17 and bytes 0x11..0x88. Then resp_valid at cycle 9 with resp_error=0 and resp_rdata=0.
- Read: preload bytes 0x11..0x88 at 0x10..0x17, then read addr=0x10 -> mem_re on addresses 0x10..0x17. resp_rdata=0x8877665544332211 at cycle 10.
- Bounds:
  - addr=1016 -> normal access.
  - addr=1017 -> resp_valid at cycle 1 with resp_error=1, and no mem_we/mem_re ever asserted.
  - addr=0xFFFFFFFFFFFFFFFC -> same error behaviour as addr=1017.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stay stable and req_ready=0; a new req_valid in that window is ignored. Then accept it after resp_ready pulses.
- Abort: assert rst_n=0 during write beat 3 -> only bytes 0..3 are written, no response, IDLE next cycle. A following read of the same address returns the new bytes 0..3 and the old bytes 4..7.
